// File: rtl/fpu_pkg.sv
// Shared opcode constants, FSM state encoding and special FP values for the
// FPU scheduler and its combinational FPU.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fpu_sched_fpu.sv
// Combinational IEEE-754 double FPU (add/sub/mul/div, round-to-nearest-even).
// Subnormal operands and results are flushed to zero.
module fpu_sched_fpu
  import fpu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [1:0]  op,
  output logic [63:0] result
);

  // m holds the significand with its binary point after bit 126
  function automatic logic [63:0] pack(input logic s, input int e, input logic [127:0] m);
    int           p;
    int           eo;
    logic [127:0] mn;
    logic [53:0]  r;
    logic         rnd;
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    mn  = m << (127 - p);
    eo  = e + p - 126;
    rnd = mn[74] & ((|mn[73:0]) | mn[75]);
    r   = {1'b0, mn[127:75]} + {53'b0, rnd};
    if (r[53]) eo = eo + 1;
    if (m == '0)       pack = 64'h0;
    else if (eo >= 2047) pack = {s, 11'h7ff, 52'b0};
    else if (eo <= 0)    pack = {s, 63'b0};
    else                 pack = {s, eo[10:0], (r[53] ? 52'b0 : r[51:0])};
  endfunction

  logic        sa, sb, sbe;
  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic [52:0] ma, mb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sbe    = sb ^ (op == OP_SUB);
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign a_nan  = (ea == 11'h7ff) && (fa != '0);
  assign b_nan  = (eb == 11'h7ff) && (fb != '0);
  assign a_inf  = (ea == 11'h7ff) && (fa == '0);
  assign b_inf  = (eb == 11'h7ff) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  logic         a_big, sx, sy;
  logic [10:0]  ex, d;
  logic [52:0]  mx, my;
  logic [255:0] ysh;
  logic [127:0] x, y, sum;

  assign a_big = a[62:0] >= b[62:0];
  assign sx    = a_big ? sa : sbe;
  assign sy    = a_big ? sbe : sa;
  assign ex    = a_big ? ea : eb;
  assign d     = a_big ? ea - eb : eb - ea;
  assign mx    = a_big ? ma : mb;
  assign my    = a_big ? mb : ma;
  assign x     = {1'b0, mx, 74'b0};
  // bits shifted past the window collapse into a sticky bit for rounding
  assign ysh   = {1'b0, my, 202'b0} >> d;
  assign y     = ysh[255:128] | {127'b0, |ysh[127:0]};
  assign sum   = (sx ^ sy) ? x - y : x + y;

  logic [105:0] prod;
  logic [127:0] num, den, quo, rem;

  assign prod = {53'b0, ma} * {53'b0, mb};
  assign num  = {ma, 75'b0};
  assign den  = {75'b0, mb};
  assign quo  = num / den;
  assign rem  = num % den;

  always_comb begin
    result = QNAN;
    case (op)
      OP_ADD, OP_SUB: begin
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) result = QNAN;
        else if (a_inf)               result = a;
        else if (b_inf)               result = {sbe, b[62:0]};
        else if (a_zero && b_zero)    result = {sa & sbe, 63'b0};
        else if (a_zero)              result = {sbe, b[62:0]};
        else if (b_zero)              result = a;
        else                          result = pack(sx, int'(ex), sum);
      end
      OP_MUL: begin
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) result = QNAN;
        else if (a_inf || b_inf)   result = {sa ^ sb, 11'h7ff, 52'b0};
        else if (a_zero || b_zero) result = {sa ^ sb, 63'b0};
        else result = pack(sa ^ sb, int'(ea) + int'(eb) - 1023, {prod, 22'b0});
      end
      default: begin
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) result = QNAN;
        else if (a_inf || b_zero) result = {sa ^ sb, 11'h7ff, 52'b0};
        else if (a_zero || b_inf) result = {sa ^ sb, 63'b0};
        else result = pack(sa ^ sb, int'(ea) - int'(eb) + 1023,
                           (quo << 51) | {127'b0, rem != '0});
      end
    endcase
  end

endmodule

// File: rtl/fpu_sched.sv
// Two-requester scheduler in front of a shared combinational FPU: round-robin
// grant, operand capture, fixed settle time, then a held response.
//   state   | meaning
//   ST_IDLE | waiting for a request; ready offered to the granted requester
//   ST_EXEC | FPU inputs held from captured operands while the counter runs
//   ST_RESP | result held on resp_* until the consumer accepts it
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result,
  output logic        resp_id,
  output logic        busy
);

  state_t      state;
  logic        last_grant, id_q;
  logic [3:0]  cnt;
  logic [63:0] a_q, b_q, fpu_result;
  logic [1:0]  op_q;
  logic        idle, grant_id, hs;

  assign idle       = (state == ST_IDLE);
  // on a tie the requester not served last wins
  assign grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = idle & req0_valid & ~grant_id;
  assign req1_ready = idle & req1_valid & grant_id;
  assign hs         = req0_ready | req1_ready;
  assign busy       = ~idle;

  fpu_sched_fpu u_fpu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (fpu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_id     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs) begin
            a_q        <= grant_id ? req1_a : req0_a;
            b_q        <= grant_id ? req1_b : req0_b;
            op_q       <= grant_id ? req1_op : req0_op;
            id_q       <= grant_id;
            last_grant <= grant_id;
            cnt        <= 4'(SETTLE_CYCLES - 1);
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            resp_result <= fpu_result;
            resp_id     <= id_q;
            resp_valid  <= 1'b1;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
